// File: rtl/circ_mvm_arbiter.sv
// Round-robin arbiter sharing one circulant matrix-vector multiply datapath among NUM_REQ requesters.
// Latency: accept -> rsp_valid is 3 cycles plus the datapath latency; optional watchdog via CIRC_MVM_ARB_TIMEOUT_EN.
// Backpressure: one job in flight; req_ready is low outside IDLE and the response holds until rsp_ready.
module circ_mvm_arbiter #(
  parameter int WORD_WIDTH     = 31,
  parameter int MTX_SIZE       = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_REQ-1:0]                               req_valid,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic [0:NUM_REQ-1][0:MTX_SIZE-1][WORD_WIDTH-1:0] req_mtx_row,
  input  logic [0:NUM_REQ-1][0:MTX_SIZE-1][WORD_WIDTH-1:0] req_vec,
  output logic                                             dp_reset,
  output logic [0:MTX_SIZE-1][WORD_WIDTH-1:0]              dp_mtx_row,
  output logic [0:MTX_SIZE-1][WORD_WIDTH-1:0]              dp_vec,
  input  logic [0:MTX_SIZE-1][WORD_WIDTH-1:0]              dp_result,
  input  logic                                             dp_valid,
  output logic                                             rsp_valid,
  input  logic                                             rsp_ready,
  output logic [ID_W-1:0]                                  rsp_id,
  output logic [0:MTX_SIZE-1][WORD_WIDTH-1:0]              rsp_result,
  output logic                                             rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_n;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_n;
  logic [ID_W-1:0]    grant;
  logic               grant_found;
  logic [NUM_REQ-1:0] rot_valid;
  logic [ID_W:0]      grant_sum;
  logic [ID_W:0]      ptr_inc;
  logic               accept;
  logic               cap_ok;
  logic               cap_err;
  logic               expire;

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_sum   = '0;
    rot_valid   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
          grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
        end
        grant = grant_sum[ID_W-1:0];
      end
    end
  end

  // Pointer advances to the requester after the one just granted.
  always_comb begin
    ptr_inc  = {1'b0, grant} + (ID_W+1)'(1);
    rr_ptr_n = ptr_inc[ID_W-1:0];
    if (ptr_inc == (ID_W+1)'(NUM_REQ)) begin
      rr_ptr_n = '0;
    end
  end

  assign accept    = (state == S_IDLE) && grant_found && !reset;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign dp_reset  = reset || (state == S_LAUNCH);
  assign rsp_valid = (state == S_RESP);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; dp_valid only matters in WAIT so stale results are ignored.
  always_comb begin
    state_n = state;
    cap_ok  = 1'b0;
    cap_err = 1'b0;
    case (state)
      S_IDLE:   if (accept) state_n = S_LAUNCH;
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        if (dp_valid) begin
          cap_ok  = 1'b1;
          state_n = S_RESP;
        end else if (expire) begin
          cap_err = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP:   if (rsp_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Round-robin pointer and operand latch, captured at the accept handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      rsp_id     <= '0;
      dp_mtx_row <= '0;
      dp_vec     <= '0;
    end else if (accept) begin
      rr_ptr     <= rr_ptr_n;
      rsp_id     <= grant;
      dp_mtx_row <= req_mtx_row[grant];
      dp_vec     <= req_vec[grant];
    end
  end

  // Result capture; a watchdog expiry returns an all-zero result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result <= '0;
    end else if (cap_ok) begin
      rsp_result <= dp_result;
    end else if (cap_err) begin
      rsp_result <= '0;
    end
  end

`ifdef CIRC_MVM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Watchdog counter: cleared while launching, counts each WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Error flag follows whichever event ended the WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cap_ok) begin
      err_q <= 1'b0;
    end else if (cap_err) begin
      err_q <= 1'b1;
    end
  end

  assign expire  = (state == S_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_circ_mvm_arbiter.sv
// Bench for circ_mvm_arbiter: plays the datapath with random latency, drives random and directed jobs.
// Expected outputs come from a transaction-level model of the arbiter and the circulant product.
// Literal expectations pin identity, modular, round-robin, backpressure, reset and timeout cases.
module tb_circ_mvm_arbiter;
  localparam int W  = 31;
  localparam int N  = 16;
  localparam int NR = 2;
  localparam int TO = 8;
  localparam longint unsigned P = 64'd2147483647;

  typedef logic [0:N-1][W-1:0] vec_t;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NR-1:0]               req_valid;
  logic [NR-1:0]               req_ready;
  logic [0:NR-1][0:N-1][W-1:0] req_mtx_row;
  logic [0:NR-1][0:N-1][W-1:0] req_vec;
  logic                        dp_reset;
  vec_t                        dp_mtx_row, dp_vec, dp_result, rsp_result;
  logic                        dp_valid;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_id;
  logic                        rsp_err;

  circ_mvm_arbiter #(.WORD_WIDTH(W), .MTX_SIZE(N), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mtx_row(req_mtx_row), .req_vec(req_vec), .dp_reset(dp_reset),
    .dp_mtx_row(dp_mtx_row), .dp_vec(dp_vec), .dp_result(dp_result), .dp_valid(dp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < N; k++) begin
        if (act[k] !== exp[k]) begin
          $display("FAIL %s: element %0d got %0d expected %0d", name, k, act[k], exp[k]);
          break;
        end
      end
    end
  endtask

  // result[i] = sum_j row[(j-i) mod N] * vec[j] mod p
  function automatic vec_t circ(input vec_t row, input vec_t v);
    vec_t r;
    longint unsigned acc;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int j = 0; j < N; j++) begin
        acc = (acc + (64'(row[(j - i + N) % N]) * 64'(v[j])) % P) % P;
      end
      r[i] = acc[W-1:0];
    end
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 2147483646));
    return v;
  endfunction

  // ---------------- reference model state ----------------
  int   cyc = 0;
  bit   m_busy, m_got, m_err;
  int   m_acc, m_rcyc, m_id, m_ptr;
  vec_t m_row, m_vec, m_res;
  int   g;
  logic [NR-1:0] exp_ready;
  bit   exp_rv;

  // observation log
  int   q_id[$];
  int   q_cyc[$];
  bit   q_err[$];
  vec_t q_res[$];
  int   acc_last, dprst_n, dprst_cyc;

  // datapath model
  bit dp_busy = 0;
  int dp_cnt = 0;
  int dp_force = -1;

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 12;
    if (r == 1) return TO - 1;
    return $urandom_range(0, 6);
  endfunction

  // Compare process plus model update, once per cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_dp_reset", dp_reset, 1);
      chk("rst_rsp_result_zero", rsp_result == '0, 1);
      chk("rst_dp_zero", (dp_mtx_row == '0) && (dp_vec == '0), 1);
      m_busy = 0; m_got = 0; m_ptr = 0;
    end else begin
      g = model_grant();
      exp_ready = '0;
      if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("dp_reset", dp_reset, m_busy && (cyc == m_acc + 1));
      exp_rv = m_busy && m_got && (cyc >= m_rcyc);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_err);
        chkv("rsp_result", rsp_result, m_res);
      end
      if (m_busy) begin
        chkv("dp_mtx_row", dp_mtx_row, m_row);
        chkv("dp_vec", dp_vec, m_vec);
      end
      // observation log
      if (rsp_valid && rsp_ready) begin
        q_id.push_back(int'(rsp_id)); q_cyc.push_back(cyc);
        q_err.push_back(rsp_err); q_res.push_back(rsp_result);
      end
      if (|(req_valid & req_ready)) begin acc_last = cyc; dprst_n = 0; end
      if (dp_reset) begin dprst_n++; dprst_cyc = cyc; end
      // model transition at the coming rising edge
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_got = 0; m_acc = cyc; m_id = g;
          m_row = req_mtx_row[g]; m_vec = req_vec[g];
          m_ptr = (g + 1) % NR;
        end
      end else if (!m_got) begin
        if (cyc >= m_acc + 2) begin
          if (dp_valid) begin
            m_got = 1; m_rcyc = cyc + 1; m_err = 0; m_res = circ(m_row, m_vec);
          end
`ifdef CIRC_MVM_ARB_TIMEOUT_EN
          else if (cyc == m_acc + 1 + TO) begin
            m_got = 1; m_rcyc = cyc + 1; m_err = 1; m_res = '0;
          end
`endif
        end
      end else if (cyc >= m_rcyc && rsp_ready) begin
        m_busy = 0;
      end
    end
    // datapath latency bookkeeping
    if (dp_reset) begin
      dp_busy = 1;
      dp_cnt = (dp_force >= 0) ? dp_force : pick_lat();
      dp_force = -1;
    end else if (dp_busy && dp_cnt > 0) begin
      dp_cnt--;
    end
  end

  // Datapath stand-in: result from its operand inputs after the latency; noise while never started.
  always @(posedge clk) begin
    #1;
    if (dp_busy) begin
      dp_valid  = (dp_cnt == 0);
      dp_result = circ(dp_mtx_row, dp_vec);
    end else begin
      dp_valid  = ($urandom_range(0, 3) == 0);
      dp_result = rnd_vec();
    end
  end

  task automatic run_job(input int r, input vec_t row, input vec_t v, input bit rdy);
    bit ok;
    req_mtx_row[r] = row; req_vec[r] = v; req_valid[r] = 1'b1; rsp_ready = rdy;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) begin ok = 1; break; end
    end
    chk("accept_within_bound", ok, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0; req_mtx_row[r] = rnd_vec(); req_vec[r] = rnd_vec();
  endtask

  task automatic wait_rsp(input int n_before, input int target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (q_id.size() >= n_before + target) begin ok = 1; break; end
    end
    chk("response_within_bound", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no end expected end");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t row, v, expv;
    int n0;
    bit ok;
    reset = 1; req_valid = '0; rsp_ready = 0;
    req_mtx_row = '0; req_vec = '0; dp_valid = 0; dp_result = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;

    // identity row, requester 0, datapath latency 2
    row = '0; row[0] = 1;
    for (int i = 0; i < N; i++) v[i] = W'(i + 1);
    n0 = q_id.size(); dp_force = 2;
    run_job(0, row, v, 1);
    wait_rsp(n0, 1);
    if (q_id.size() > n0) begin
      chk("identity_id", q_id[n0], 0);
      chk("identity_err", q_err[n0], 0);
      for (int i = 0; i < N; i++) expv[i] = W'(i + 1);
      chkv("identity_result", q_res[n0], expv);
      chk("identity_latency", q_cyc[n0] - acc_last, 5);
    end
    chk("identity_dp_reset_count", dprst_n, 1);
    chk("identity_dp_reset_cycle", dprst_cyc - acc_last, 1);

    // modular wrap, requester 1
    row = '0; row[0] = 31'd2147483646;
    v = '0; v[0] = 2;
    n0 = q_id.size();
    run_job(1, row, v, 1);
    wait_rsp(n0, 1);
    if (q_id.size() > n0) begin
      expv = '0; expv[0] = 31'd2147483645;
      chkv("modular_result", q_res[n0], expv);
      chk("modular_id", q_id[n0], 1);
    end

    // round-robin with both requesters asserting continuously
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < N; i++) begin req_mtx_row[r][i] = 1; req_vec[r][i] = 1; end
    end
    n0 = q_id.size(); rsp_ready = 1; req_valid = 2'b11;
    wait_rsp(n0, 4);
    @(posedge clk); #1; req_valid = '0;
    for (int i = 0; i < N; i++) expv[i] = 16;
    for (int k = 0; k < 4; k++) begin
      if (q_id.size() > n0 + k) begin
        chk($sformatf("rr_grant_%0d", k), q_id[n0 + k], k % 2);
        chkv($sformatf("rr_result_%0d", k), q_res[n0 + k], expv);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // backpressure: response held 10 cycles while requester 1 waits
    row = '0; row[0] = 3;
    for (int i = 0; i < N; i++) v[i] = W'(i);
    for (int i = 0; i < N; i++) expv[i] = W'(3 * i);
    dp_force = 1;
    run_job(0, row, v, 0);
    req_valid[1] = 1'b1;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("bp_rsp_valid_within_bound", ok, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 0);
      chkv("bp_rsp_result", rsp_result, expv);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1; rsp_ready = 1;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) begin ok = 1; break; end
    end
    chk("bp_next_grant_within_bound", ok, 1);
    @(posedge clk); #1; req_valid = '0;
    repeat (20) @(posedge clk);
    #1;

    // reset while in WAIT drops the job
    n0 = q_id.size(); dp_force = 20;
    run_job(1, rnd_vec(), rnd_vec(), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; req_valid = 2'b11;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_dp_reset", dp_reset, 1);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk); #1 reset = 0;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin ok = 1; break; end
    end
    chk("postrst_accept_within_bound", ok, 1);
    chk("postrst_grant", req_ready, 2'b01);
    @(posedge clk); #1; req_valid = '0;
    wait_rsp(n0, 1);
    chk("postrst_single_response", q_id.size(), n0 + 1);
    if (q_id.size() > n0) chk("postrst_rsp_id", q_id[n0], 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid = NR'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NR; r++) begin
        req_mtx_row[r] = rnd_vec(); req_vec[r] = rnd_vec();
      end
    end
    @(posedge clk); #1; req_valid = '0; rsp_ready = 1;
    repeat (40) @(posedge clk);
    #1;

`ifdef CIRC_MVM_ARB_TIMEOUT_EN
    // watchdog expiry with a stalled datapath
    n0 = q_id.size(); dp_force = 30;
    run_job(0, rnd_vec(), rnd_vec(), 1);
    wait_rsp(n0, 1);
    if (q_id.size() > n0) begin
      chk("timeout_err", q_err[n0], 1);
      chk("timeout_result_zero", q_res[n0] == '0, 1);
      chk("timeout_latency", q_cyc[n0] - acc_last, 2 + TO);
    end
    repeat (40) @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/circ_mvm_arbiter.md
# circ_mvm_arbiter

Shares one `circ_mtx_vec_mul` datapath among `NUM_REQ` requesters with round-robin arbitration. Per job it latches one requester's circulant first row and vector, restarts the datapath, waits for its `valid`, and returns the M31 result tagged with the requester index over a valid/ready response channel. It sits between the Monolith round logic (requesters) and the shared MDS-style multiply datapath.

## Interface
- `WORD_WIDTH`, 31: field element width (M31, p = 2^31−1).
- `MTX_SIZE`, 16: vector length / matrix dimension.
- `NUM_REQ`, 2: number of requesters, ≥1.
- `TIMEOUT_CYCLES`, 64: watchdog limit; only used with `CIRC_MVM_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in NUM_REQ: per-requester job request.
- `req_ready` out NUM_REQ: per-requester accept.
- `req_mtx_row` in [0:NUM_REQ-1][0:MTX_SIZE-1] × WORD_WIDTH: first rows.
- `req_vec` in [0:NUM_REQ-1][0:MTX_SIZE-1] × WORD_WIDTH: vectors.
- `dp_reset` out 1: datapath reset/restart.
- `dp_mtx_row` out [0:MTX_SIZE-1] × WORD_WIDTH: latched row to datapath.
- `dp_vec` out [0:MTX_SIZE-1] × WORD_WIDTH: latched vector to datapath.
- `dp_result` in [0:MTX_SIZE-1] × WORD_WIDTH: datapath result.
- `dp_valid` in 1: datapath result valid.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_id` out $clog2(NUM_REQ) (min 1): index of the requester served.
- `rsp_result` out [0:MTX_SIZE-1] × WORD_WIDTH: captured result.
- `rsp_err` out 1: watchdog expiry flag (0 when macro absent).

## Operation
- FSM states: IDLE → LAUNCH → WAIT → RESP → IDLE.
- IDLE: `grant` = first i with `req_valid[i]`, searching cyclically from `rr_ptr`. `req_ready[grant]`=1 combinationally; all other bits 0. With no valid request, all `req_ready`=0. On handshake, latch the row and vector into the `dp_*` registers, record `grant` as `rsp_id`, set `rr_ptr` ← (grant+1) mod NUM_REQ, and go to LAUNCH.
- LAUNCH: one cycle. `dp_reset`=1. Then go to WAIT.
- WAIT: `dp_valid` is sampled only in this state, so a stale valid from a previous job is ignored. On `dp_valid`=1, capture `dp_result` into `rsp_result`, set `rsp_err`=0, and go to RESP.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_result` and `rsp_err` hold stable until `rsp_valid && rsp_ready`, then go to IDLE. No request is accepted while not in IDLE.
- `dp_reset` = `reset` OR (state==LAUNCH).
- `dp_mtx_row` and `dp_vec` are held constant from accept until the return to IDLE.
- Requester operands must stay stable only in the handshake cycle.
- Arithmetic is done entirely by the datapath: result[i] = Σ_j mtx_row[(j−i) mod MTX_SIZE]·vec[j] mod p. The controller does not alter any values.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=all 0, `rsp_err`=0, `dp_mtx_row`/`dp_vec`=all 0. `dp_reset`=1 while `reset` is high.
- Job sequence: accept at cycle T, LAUNCH at T+1, WAIT from T+2. If `dp_valid` is first seen high at cycle W, `rsp_valid` rises at W+1.
- Response: accepted at cycle R, state is IDLE at R+1, and the next accept happens at R+1 at the earliest.
- Minimum accept-to-`rsp_valid` time is 3 cycles plus the datapath latency.
- Reset mid-job (any state): immediate return to the reset values. The in-flight job is dropped with no response, and `rr_ptr` returns to 0.
- `rsp_ready` held high before RESP has no effect.
- `NUM_REQ`=1: arbitration degenerates to always grant index 0.

## Configuration
- `CIRC_MVM_ARB_TIMEOUT_EN` defined: a cycle counter is cleared on entry to WAIT and increments every WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` with `dp_valid` still 0, go to RESP with `rsp_err`=1 and `rsp_result`=all 0.
  - `dp_valid` in the same cycle as expiry wins, giving `rsp_err`=0.
- Macro undefined: no counter exists, WAIT waits indefinitely, and `rsp_err` is tied to 0.

## Test plan
- Identity: `mtx_row`={1,0,…,0}, `vec`={1,2,…,16} from requester 0 → `rsp_result`={1,…,16}, `rsp_id`=0, `rsp_err`=0. Check `dp_reset` is high for exactly one cycle, at T+1.
- Modular: `mtx_row`[0]=2147483646 (p−1), others 0; `vec`={2,0,…} → `rsp_result`[0]=2147483645, all other elements 0.
- Round-robin: requesters 0 and 1 hold `req_valid` high continuously with `rsp_ready`=1 → grants alternate 0,1,0,1. All-ones operands give every element of every result = 16.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_result` stay stable, and `req_ready` stays 0 throughout.
- Reset in WAIT: assert `reset` → all outputs immediately return to reset values, and no response is produced. The next job after release is granted to requester 0.
- With `CIRC_MVM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: hold `dp_valid`=0 → `rsp_valid`=1 with `rsp_err`=1 and zero result, arriving 8 cycles after entering WAIT.
